sdram_port_arbiter: RTL and testbench

Shares the `block_ram_dual_port` SDRAM model between two requesters: requester 0 is the `axi_interface_slave` memory side (`o_we`/`o_re`), and requester 1 is an on-chip engine (DMA/crypto).
- The RAM read port and write port are arbitrated independently, each with its own round-robin pointer.
- The block tracks in-flight reads and routes returned data to the issuing requester.
- It sits between `slave_0_sdram`'s interface logic and `sdram_inst`.

---
 rtl/sdram_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares one dual-port SDRAM model (one write port, one read port) between
//   two requesters: 0 = AXI slave memory side, 1 = on-chip engine.
//   Write and read ports are arbitrated independently.
//
//   Build option: SDRAM_ARB_FIXED_PRIO_EN
//     defined   -> requester 0 always wins contention, no pointers
//     undefined -> round-robin with last-winner pointers (default)
//
//   Ports (n = 0, 1):
//     clk_i, rst_ni                 clock, async active-low reset
//     wreq_n_i/waddr_n_i/wdata_n_i  write request, held until wgnt_n_o
//     wgnt_n_o                      write grant (combinational)
//     rreq_n_i/raddr_n_i            read request, held until rgnt_n_o
//     rgnt_n_o                      read grant (combinational)
//     rvalid_n_o/rdata_n_o          read return, RD_LAT cycles after grant
//     ram_we_o/ram_waddr_o/ram_wdata_o   RAM write port
//     ram_re_o/ram_raddr_o/ram_rdata_i   RAM read port
module sdram_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wreq_0_i,
    input  logic [ADDR_WIDTH-1:0] waddr_0_i,
    input  logic [DATA_WIDTH-1:0] wdata_0_i,
    output logic                  wgnt_0_o,
    input  logic                  rreq_0_i,
    input  logic [ADDR_WIDTH-1:0] raddr_0_i,
    output logic                  rgnt_0_o,
    output logic                  rvalid_0_o,
    output logic [DATA_WIDTH-1:0] rdata_0_o,
    input  logic                  wreq_1_i,
    input  logic [ADDR_WIDTH-1:0] waddr_1_i,
    input  logic [DATA_WIDTH-1:0] wdata_1_i,
    output logic                  wgnt_1_o,
    input  logic                  rreq_1_i,
    input  logic [ADDR_WIDTH-1:0] raddr_1_i,
    output logic                  rgnt_1_o,
    output logic                  rvalid_1_o,
    output logic [DATA_WIDTH-1:0] rdata_1_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_waddr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    output logic                  ram_re_o,
    output logic [ADDR_WIDTH-1:0] ram_raddr_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

    logic [1:0]                 wreq, rreq;
    logic [1:0][ADDR_WIDTH-1:0] waddr, raddr;
    logic [1:0][DATA_WIDTH-1:0] wdata;

    assign wreq  = {wreq_1_i, wreq_0_i};
    assign rreq  = {rreq_1_i, rreq_0_i};
    assign waddr = {waddr_1_i, waddr_0_i};
    assign raddr = {raddr_1_i, raddr_0_i};
    assign wdata = {wdata_1_i, wdata_0_i};

    // wsel/rsel name the candidate winner; only meaningful when a request exists
    logic       wsel, rsel;
    logic       wgo, rgo, hazard;
    logic [1:0] wgnt, rgnt;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    assign wsel = ~wreq[0];
    assign rsel = ~rreq[0];
`else
    // last winner per port; reset to 1 so requester 0 wins first contention
    logic wlast, rlast;

    assign wsel = wreq[1] & (~wreq[0] | ~wlast);
    assign rsel = rreq[1] & (~rreq[0] | ~rlast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wlast <= 1'b1;
            rlast <= 1'b1;
        end else begin
            if (wgo) wlast <= wsel;
            if (rgo) rlast <= rsel;   // withheld reads leave the pointer alone
        end
    end
`endif

    // Grants are forced low while reset is asserted.
    assign wgo = rst_ni & (|wreq);

    // A read to the word being written this cycle is held off one cycle so it
    // can never return pre-write data.
    assign hazard = wgo & (|rreq) &
                    (waddr[wsel][ADDR_WIDTH-1:2] == raddr[rsel][ADDR_WIDTH-1:2]);
    assign rgo    = rst_ni & (|rreq) & ~hazard;

    assign wgnt = wgo ? (wsel ? 2'b10 : 2'b01) : 2'b00;
    assign rgnt = rgo ? (rsel ? 2'b10 : 2'b01) : 2'b00;

    assign wgnt_0_o = wgnt[0];
    assign wgnt_1_o = wgnt[1];
    assign rgnt_0_o = rgnt[0];
    assign rgnt_1_o = rgnt[1];

    assign ram_we_o    = wgo;
    assign ram_waddr_o = wgo ? waddr[wsel] : '0;
    assign ram_wdata_o = wgo ? wdata[wsel] : '0;
    assign ram_re_o    = rgo;
    assign ram_raddr_o = rgo ? raddr[rsel] : '0;

    // Return tracking: bit 0 enters at the grant edge, bit RD_LAT-1 lines up
    // with ram_rdata_i. Reset drops everything in flight.
    logic [RD_LAT-1:0] vld_pipe, own_pipe;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
            own_pipe <= '0;
        end else begin
            vld_pipe <= (vld_pipe << 1) | RD_LAT'(rgo);
            own_pipe <= (own_pipe << 1) | RD_LAT'(rsel);
        end
    end

    assign rvalid_0_o = vld_pipe[RD_LAT-1] & ~own_pipe[RD_LAT-1];
    assign rvalid_1_o = vld_pipe[RD_LAT-1] &  own_pipe[RD_LAT-1];
    assign rdata_0_o  = rvalid_0_o ? ram_rdata_i : '0;
    assign rdata_1_o  = rvalid_1_o ? ram_rdata_i : '0;

`ifndef SYNTHESIS
    // Requesters must hold request and payload until granted.
    for (genvar n = 0; n < 2; n++) begin : g_stable
        a_wstable : assert property (@(posedge clk_i) disable iff (!rst_ni)
            (wreq[n] && !wgnt[n]) |=> (wreq[n] && $stable(waddr[n]) && $stable(wdata[n])));
        a_rstable : assert property (@(posedge clk_i) disable iff (!rst_ni)
            (rreq[n] && !rgnt[n]) |=> (rreq[n] && $stable(raddr[n])));
    end
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wreq0 = 0, wreq1 = 0, rreq0 = 0, rreq1 = 0;
    logic [AW-1:0] waddr0 = '0, waddr1 = '0, raddr0 = '0, raddr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic wgnt0, wgnt1, rgnt0, rgnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic ram_we, ram_re;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(RD_LAT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wreq_0_i(wreq0), .waddr_0_i(waddr0), .wdata_0_i(wdata0), .wgnt_0_o(wgnt0),
        .rreq_0_i(rreq0), .raddr_0_i(raddr0), .rgnt_0_o(rgnt0),
        .rvalid_0_o(rvalid0), .rdata_0_o(rdata0),
        .wreq_1_i(wreq1), .waddr_1_i(waddr1), .wdata_1_i(wdata1), .wgnt_1_o(wgnt1),
        .rreq_1_i(rreq1), .raddr_1_i(raddr1), .rgnt_1_o(rgnt1),
        .rvalid_1_o(rvalid1), .rdata_1_o(rdata1),
        .ram_we_o(ram_we), .ram_waddr_o(ram_waddr), .ram_wdata_o(ram_wdata),
        .ram_re_o(ram_re), .ram_raddr_o(ram_raddr), .ram_rdata_i(ram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM environment: write commits at the edge, read data RD_LAT cycles later
    bit   [DW-1:0] ram_mem [256];
    logic [DW-1:0] rpipe [RD_LAT];
    always @(posedge clk) begin
        rpipe[0] <= ram_re ? ram_mem[ram_raddr[9:2]] : '0;
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
        if (ram_we) ram_mem[ram_waddr[9:2]] <= ram_wdata;
    end
    assign ram_rdata = rpipe[RD_LAT-1];

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic w0, w1, r0, r1;
        logic [1:0] wg, rg;   // {gnt1, gnt0}
    } vec_t;
    vec_t tbl [10];

    typedef struct {
        int          due;
        int          own;
        logic [DW-1:0] data;
    } ret_t;
    ret_t rq [$];

    // who wins when a/b request; -1 for nobody
    function automatic int pick(bit a, bit b, int last);
        if (a && b) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            return 0;
`else
            return 1 - last;
`endif
        end
        if (a) return 0;
        if (b) return 1;
        return -1;
    endfunction

    bit   [DW-1:0] mem_m [256];
    bit            pw [2], pr [2];
    logic [AW-1:0] wa [2], ra [2];
    logic [DW-1:0] wd [2];
    int            wl_m, rl_m;

    initial begin
        tbl[0] = '{1,1,1,1, 2'b01, 2'b01};
        tbl[1] = '{1,1,1,1, 2'b10, 2'b10};
        tbl[2] = '{1,1,1,0, 2'b01, 2'b01};
        tbl[3] = '{1,1,0,1, 2'b10, 2'b10};
        tbl[4] = '{1,0,0,0, 2'b01, 2'b00};
        tbl[5] = '{0,1,1,0, 2'b10, 2'b01};
        tbl[6] = '{0,1,1,1, 2'b10, 2'b10};
        tbl[7] = '{1,1,1,0, 2'b01, 2'b01};
        tbl[8] = '{0,1,1,1, 2'b10, 2'b10};
        tbl[9] = '{0,0,1,0, 2'b00, 2'b01};

        // reset with every request high
        waddr0 = 32'h10; wdata0 = 32'hA0A0_0010;
        waddr1 = 32'h20; wdata1 = 32'hB1B1_0020;
        raddr0 = 32'h100; raddr1 = 32'h200;
        wreq0 = 1; wreq1 = 1; rreq0 = 1; rreq1 = 1;
        @(negedge clk);
        chk("rst wgnt", {wgnt1, wgnt0}, 2'b00);
        chk("rst rgnt", {rgnt1, rgnt0}, 2'b00);
        chk("rst en", {ram_we, ram_re}, 2'b00);
        chk("rst rvalid", {rvalid1, rvalid0}, 2'b00);
        chk("rst waddr", ram_waddr, 0);
        chk("rst raddr", ram_raddr, 0);
        next_cycle();
        rst_n = 1;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("fp%0d rgnt", i), {rgnt1, rgnt0}, 2'b01);
            chk($sformatf("fp%0d wgnt", i), {wgnt1, wgnt0}, 2'b01);
            next_cycle();
        end
        wreq0 = 0; rreq0 = 0;
        @(negedge clk);
        chk("fp tail wgnt", {wgnt1, wgnt0}, 2'b10);
        chk("fp tail rgnt", {rgnt1, rgnt0}, 2'b10);
        next_cycle();
`else
        for (int i = 0; i < 10; i++) begin
            wreq0 = tbl[i].w0; wreq1 = tbl[i].w1;
            rreq0 = tbl[i].r0; rreq1 = tbl[i].r1;
            @(negedge clk);
            chk($sformatf("tbl%0d wgnt", i), {wgnt1, wgnt0}, tbl[i].wg);
            chk($sformatf("tbl%0d rgnt", i), {rgnt1, rgnt0}, tbl[i].rg);
            chk($sformatf("tbl%0d en", i), {ram_we, ram_re}, {|tbl[i].wg, |tbl[i].rg});
            chk($sformatf("tbl%0d waddr", i), ram_waddr,
                tbl[i].wg[1] ? 64'h20 : (tbl[i].wg[0] ? 64'h10 : 64'h0));
            chk($sformatf("tbl%0d raddr", i), ram_raddr,
                tbl[i].rg[1] ? 64'h200 : (tbl[i].rg[0] ? 64'h100 : 64'h0));
            next_cycle();
        end
`endif
        wreq0 = 0; wreq1 = 0; rreq0 = 0; rreq1 = 0;
        repeat (3) next_cycle();
        chk("ram word 0x10", ram_mem[8'h04], 32'hA0A0_0010);
        chk("ram word 0x20", ram_mem[8'h08], 32'hB1B1_0020);

        // read return, RD_LAT=2
        rreq1 = 1; raddr1 = 32'h20;
        @(negedge clk);
        chk("rr gnt", {rgnt1, rgnt0}, 2'b10);
        next_cycle();
        rreq1 = 0;
        @(negedge clk);
        chk("rr t+1 rvalid", {rvalid1, rvalid0}, 2'b00);
        next_cycle();
        @(negedge clk);
        chk("rr t+2 rvalid", {rvalid1, rvalid0}, 2'b10);
        chk("rr t+2 rdata1", rdata1, 32'hB1B1_0020);
        chk("rr t+2 rdata0", rdata0, 0);
        next_cycle();
        @(negedge clk);
        chk("rr t+3 rvalid", {rvalid1, rvalid0}, 2'b00);
        next_cycle();

        // hazard: same word, write wins, read retries
        wreq0 = 1; waddr0 = 32'h40; wdata0 = 32'hDEAD_BEEF;
        rreq1 = 1; raddr1 = 32'h42;
        @(negedge clk);
        chk("hz wgnt", {wgnt1, wgnt0}, 2'b01);
        chk("hz rgnt withheld", {rgnt1, rgnt0, ram_re}, 3'b000);
        next_cycle();
        wreq0 = 0;
        @(negedge clk);
        chk("hz retry rgnt", {rgnt1, rgnt0}, 2'b10);
        next_cycle();
        rreq1 = 0;
        next_cycle();
        @(negedge clk);
        chk("hz rvalid", {rvalid1, rvalid0}, 2'b10);
        chk("hz rdata", rdata1, 32'hDEAD_BEEF);
        next_cycle();

        // reset with two reads in flight
        rreq0 = 1; raddr0 = 32'h100;
        @(negedge clk);
        chk("rif gnt0", rgnt0, 1'b1);
        next_cycle();
        rreq0 = 0; rreq1 = 1; raddr1 = 32'h200;
        @(negedge clk);
        chk("rif gnt1", rgnt1, 1'b1);
        next_cycle();
        rreq1 = 0; rst_n = 0;
        @(negedge clk);
        chk("rif in reset rvalid", {rvalid1, rvalid0}, 2'b00);
        next_cycle();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rif post%0d rvalid", i), {rvalid1, rvalid0}, 2'b00);
            next_cycle();
        end
        // pointer cleared: requester 0 wins again though it won last
        wreq0 = 1; wreq1 = 1;
        waddr0 = 32'h14; waddr1 = 32'h24;
        @(negedge clk);
        chk("ptr clr wgnt", {wgnt1, wgnt0}, 2'b01);
        next_cycle();
        wreq0 = 0;
        @(negedge clk);
        chk("ptr clr wgnt2", {wgnt1, wgnt0}, 2'b10);
        next_cycle();
        wreq1 = 0;

        // randomized run against a request-level model
        wl_m = 1; rl_m = 1;
        for (int n = 0; n < 2; n++) begin pw[n] = 0; pr[n] = 0; end
        for (int c = 0; c < 400; c++) begin
            int w, r;
            for (int n = 0; n < 2; n++) begin
                if (c < 390 && !pw[n] && $urandom_range(0, 2) != 0) begin
                    pw[n] = 1;
                    wa[n] = 32'h300 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
                    wd[n] = $urandom;
                end
                if (c < 390 && !pr[n] && $urandom_range(0, 2) != 0) begin
                    pr[n] = 1;
                    ra[n] = 32'h300 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
                end
            end
            wreq0 = pw[0]; waddr0 = wa[0]; wdata0 = wd[0];
            wreq1 = pw[1]; waddr1 = wa[1]; wdata1 = wd[1];
            rreq0 = pr[0]; raddr0 = ra[0];
            rreq1 = pr[1]; raddr1 = ra[1];
            @(negedge clk);
            w = pick(pw[0], pw[1], wl_m);
            r = pick(pr[0], pr[1], rl_m);
            if (w >= 0 && r >= 0 && (wa[w] >> 2) == (ra[r] >> 2)) r = -1;
            chk("rnd wgnt", {wgnt1, wgnt0}, {w == 1, w == 0});
            chk("rnd rgnt", {rgnt1, rgnt0}, {r == 1, r == 0});
            if (w >= 0) chk("rnd wport", {ram_waddr, ram_wdata}, {wa[w], wd[w]});
            if (r >= 0) chk("rnd raddr", ram_raddr, ra[r]);
            if (rq.size() > 0 && rq[0].due == cyc) begin
                chk("rnd rvalid", {rvalid1, rvalid0}, {rq[0].own == 1, rq[0].own == 0});
                chk("rnd rdata", rq[0].own ? rdata1 : rdata0, rq[0].data);
                void'(rq.pop_front());
            end else begin
                chk("rnd rvalid idle", {rvalid1, rvalid0}, 2'b00);
            end
            if (r >= 0) begin
                rq.push_back('{cyc + RD_LAT, r, mem_m[ra[r][9:2]]});
                rl_m = r; pr[r] = 0;
            end
            if (w >= 0) begin
                mem_m[wa[w][9:2]] = wd[w];
                wl_m = w; pw[w] = 0;
            end
            next_cycle();
        end
        chk("rnd drained", rq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
